// File: rtl/ofm_drain_ctrl.sv
// OFM drain controller: kicks the convolution engine, then streams the output
// feature map out of OFM port A in address order, zeroing each word after it
// is read so the memory is clean for the next layer.
//
// state | meaning
// IDLE  | waiting for i_start
// CONV  | convolution engine owns the OFM; waiting for i_conv_done
// DRAIN | alternating read / clear cycles over addresses 0..N-1
// FLUSH | all words read and cleared; waiting for the FIFO to empty
// DONE  | one-cycle completion pulse
module ofm_drain_ctrl #(
  parameter int OUT_SIZE   = 2,
  parameter int DATA_WIDTH = 48,
  parameter int AW         = $clog2(OUT_SIZE**2) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_conv_done,
  output logic                  o_conv_start,
  output logic                  o_own,
  output logic [AW-1:0]         o_ofm_addr,
  output logic                  o_ofm_we,
  output logic [DATA_WIDTH-1:0] o_ofm_wdata,
  input  logic [DATA_WIDTH-1:0] i_ofm_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int N = OUT_SIZE * OUT_SIZE;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [2:0] {IDLE, CONV, DRAIN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic                  conv_start_q;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         clr_addr;
  // rd_pend marks both "read data arrives this cycle" and "clear slot this cycle"
  logic                  rd_pend;
  logic                  rd_pend_last;
  logic                  all_issued;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            fifo_cnt;

  // A read may only go out when the FIFO can absorb everything already in flight.
  assign rd_issue = (state == DRAIN) && !rd_pend && !all_issued &&
                    ((fifo_cnt + {1'b0, rd_pend}) < 2'd2);
  assign push     = rd_pend;
  assign pop      = o_valid && i_ready;

  // State register and start pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      conv_start_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      conv_start_q <= (state == IDLE) && i_start;
    end
  end

  // Read address sequencing and the pending read/clear slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_addr      <= '0;
      clr_addr     <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      all_issued   <= 1'b0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_addr == LAST_ADDR);
      if (rd_issue) clr_addr <= rd_addr;
      if (state == CONV) begin
        rd_addr    <= '0;
        all_issued <= 1'b0;
      end else if (rd_issue) begin
        // Hold at the last address instead of wrapping.
        if (rd_addr == LAST_ADDR) all_issued <= 1'b1;
        else                      rd_addr    <= rd_addr + 1'b1;
      end
    end
  end

  // Two-entry output FIFO fed by the one-cycle-latency read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      fifo_cnt     <= '0;
    end else begin
      if (push) begin
        fifo_data[wptr] <= i_ofm_rdata;
        fifo_last[wptr] <= rd_pend_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)     state_nxt = CONV;
      CONV:    if (i_conv_done) state_nxt = DRAIN;
      // Leave once the clear of the last address is on the port.
      DRAIN:   if (rd_pend && rd_pend_last) state_nxt = FLUSH;
      FLUSH:   if (fifo_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Port A drive and stream outputs.
  always_comb begin
    o_conv_start = conv_start_q;
    o_own        = (state == DRAIN) || (state == FLUSH);
    o_ofm_we     = (state == DRAIN) && rd_pend;
    o_ofm_addr   = '0;
    if (state == DRAIN) o_ofm_addr = rd_pend ? clr_addr : rd_addr;
    o_ofm_wdata  = '0;
    o_valid      = (fifo_cnt != 2'd0);
    o_data       = o_valid ? fifo_data[rptr] : '0;
    o_last       = o_valid && fifo_last[rptr];
    o_busy       = (state != IDLE);
    o_done       = (state == DONE);
  end

endmodule

// File: tb/tb_ofm_drain_ctrl.sv
// Bench for ofm_drain_ctrl: OFM memory model, expected-word queue with a
// monitor popping on each accepted word, plus a one-word (OUT_SIZE=1) instance.
module tb_ofm_drain_ctrl;
  localparam int DW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, conv_done, conv_start, own, we, valid, ready, last, busy, done;
  logic [2:0]    addr;
  logic [DW-1:0] wdata, rdata, data;

  logic          s_start, s_conv_done, s_conv_start, s_own, s_we, s_valid, s_ready;
  logic          s_last, s_busy, s_done;
  logic [0:0]    s_addr;
  logic [DW-1:0] s_wdata, s_rdata, s_data;

  ofm_drain_ctrl #(.OUT_SIZE(2), .DATA_WIDTH(DW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_conv_done(conv_done),
    .o_conv_start(conv_start), .o_own(own), .o_ofm_addr(addr), .o_ofm_we(we),
    .o_ofm_wdata(wdata), .i_ofm_rdata(rdata), .o_valid(valid), .i_ready(ready),
    .o_data(data), .o_last(last), .o_busy(busy), .o_done(done)
  );

  ofm_drain_ctrl #(.OUT_SIZE(1), .DATA_WIDTH(DW)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_conv_done(s_conv_done),
    .o_conv_start(s_conv_start), .o_own(s_own), .o_ofm_addr(s_addr), .o_ofm_we(s_we),
    .o_ofm_wdata(s_wdata), .i_ofm_rdata(s_rdata), .o_valid(s_valid), .i_ready(s_ready),
    .o_data(s_data), .o_last(s_last), .o_busy(s_busy), .o_done(s_done)
  );

  // OFM memories: synchronous read (read-before-write), written only when owned.
  logic [DW-1:0] mem [4];
  logic [DW-1:0] mem1;
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) mem[i] <= DW'(10 * (i + 1));
      mem1 <= DW'(77);
    end else begin
      if (own) begin
        rdata <= mem[addr[1:0]];
        if (we) mem[addr[1:0]] <= wdata;
      end
      if (s_own) begin
        s_rdata <= mem1;
        if (s_we) mem1 <= s_wdata;
      end
    end
  end

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0, checks = 0;
  int n_cs = 0, n_done = 0, clears = 0, accepted = 0;
  logic          prev_stall = 1'b0;
  logic          prev_last;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops an expected word per accepted word, checks hold under stall
  // and bounds the number of words read but not yet accepted.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (conv_start) n_cs++;
      if (done) n_done++;
      if (prev_stall) chk("hold", {valid, last, data}, {1'b1, prev_last, prev_data});
      if (valid && ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0d expected none", data);
        end else begin
          e = exp_q.pop_front();
          chk("word", {last, data}, {e.l, e.d});
        end
      end
      if (we) begin
        clears++;
        chk("outstanding_le_2", 64'((clears - accepted) <= 2), 64'd1);
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end
  end

  // Ready driver: 0 = always ready, 1 = 6-cycle stall on first valid, 2 = random.
  int mode = 0;
  int stall_left = 0;
  bit seen_valid = 1'b0;
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          if (!seen_valid && valid) begin
            seen_valid = 1'b1;
            stall_left = 6;
          end
          if (stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
          end else ready = 1'b1;
        end
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_expect();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: DW'(10 * (i + 1)), l: (i == 3)});
  endtask

  task automatic run_layer(input int m, input bit poke);
    int cs0, d0, k;
    mode = m;
    seen_valid = 1'b0;
    load_and_expect();
    cs0 = n_cs;
    d0  = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) begin
      tick();
      if (poke) start = 1'b1;
    end
    start = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    if (poke) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (k = 0; k < 300; k++) begin
      if (done) break;
      tick();
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL layer_timeout: got no o_done expected o_done within 300 cycles");
    end
    mode = 0;
    tick();
    chk("conv_start_pulses", 64'(n_cs - cs0), 64'd1);
    chk("done_pulses", 64'(n_done - d0), 64'd1);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) chk("ofm_zeroed", mem[i], 64'd0);
    chk("idle_after_done", busy, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; conv_done = 1'b0; preload = 1'b0;
    s_start = 1'b0; s_conv_done = 1'b0; s_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", 64'(|{conv_start, own, addr, we, wdata, valid, data, last, busy, done}), 64'd0);
    rst = 1'b0;
    tick();

    // i_conv_done while idle must be ignored
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_ignores_conv_done", busy, 64'd0);
    end

    run_layer(0, 1'b0);
    run_layer(1, 1'b0);
    run_layer(0, 1'b1);

    // Reset in the cycle the second word is accepted
    mode = 0;
    load_and_expect();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (valid && data == DW'(20)) break;
      tick();
    end
    chk("second_word_seen", 64'(k < 100), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_outputs_zero", 64'(|{conv_start, own, addr, we, wdata, valid, data, last, busy, done}), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    clears = 0;
    accepted = 0;
    chk("rst_mem0", mem[0], 64'd0);
    chk("rst_mem1", mem[1], 64'd0);
    chk("rst_mem2", mem[2], 64'd30);
    chk("rst_mem3", mem[3], 64'd40);
    tick();
    run_layer(0, 1'b0);

    for (int n = 0; n < 1000; n++) run_layer(2, 1'b0);

    // One-word layer
    preload = 1'b1;
    tick();
    preload = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (3) tick();
    s_conv_done = 1'b1;
    tick();
    s_conv_done = 1'b0;
    for (k = 0; k < 50; k++) begin
      if (s_valid) break;
      tick();
    end
    chk("s_valid", s_valid, 64'd1);
    chk("s_word", {s_last, s_data}, {1'b1, DW'(77)});
    for (k = 0; k < 50; k++) begin
      if (s_done) break;
      tick();
    end
    chk("s_done", s_done, 64'd1);
    tick();
    chk("s_mem_zero", mem1, 64'd0);
    chk("s_idle", s_busy, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
